operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Initiator side of the CPU register file interface.
- Accepts decoded instructions (source and destination register indices) over a valid/ready handshake.
- Drives the register file read ports, then registers the operands to the execute stage.
- Passes writeback requests through to the register file write port, forwards same-cycle writeback data, and holds a busy-register scoreboard that stalls RAW/WAW hazards.

Parameters:
- REG_ADDR_WIDTH, 4, register index width; NUM_REGS = 2**REG_ADDR_WIDTH.
- DATA_WIDTH, 8, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  instruction accepted this cycle when in_valid&&in_ready.
- in_rs1  input  REG_ADDR_WIDTH  source register 1.
- in_rs2  input  REG_ADDR_WIDTH  source register 2.
- in_rd  input  REG_ADDR_WIDTH  destination register.
- in_wen  input  1  instruction will write in_rd.
- out_valid  output  1  operand bundle valid.
- out_ready  input  1  execute stage accepts bundle.
- out_op1  output  DATA_WIDTH  operand 1.
- out_op2  output  DATA_WIDTH  operand 2.
- out_rd  output  REG_ADDR_WIDTH  destination register, carried through.
- out_wen  output  1  write enable, carried through.
- wb_valid  input  1  writeback request.
- wb_rd  input  REG_ADDR_WIDTH  writeback register.
- wb_data  input  DATA_WIDTH  writeback data.
- rf_reg1  output  REG_ADDR_WIDTH  register file read address 1.
- rf_reg2  output  REG_ADDR_WIDTH  register file read address 2.
- rf_data1  input  DATA_WIDTH  register file read data 1 (combinational).
- rf_data2  input  DATA_WIDTH  register file read data 2 (combinational).
- rf_write_en  output  1  register file write enable.
- rf_regw  output  REG_ADDR_WIDTH  register file write address.
- rf_dataw  output  DATA_WIDTH  register file write data.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is synchronous, active-low.
- Reset values:
  - out_valid=0; out_op1, out_op2, out_rd, out_wen = 0.
  - busy[NUM_REGS-1:0] = 0.
  - rf_write_en forced 0 while rst_n=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation discards the held bundle and clears the scoreboard.
- Register file contract:
  - Reads are combinational.
  - Write commits at the posedge where rf_write_en=1.
  - A same-cycle read of the register being written returns the old value, so this block forwards.
  - No hardwired zero register.
- Read ports: rf_reg1=in_rs1, rf_reg2=in_rs2, combinational, always driven.
- Write port: rf_write_en=wb_valid&&rst_n; rf_regw=wb_rd; rf_dataw=wb_data; combinational pass-through.
- Forwarding:
  - op1_next = (wb_valid && wb_rd==in_rs1) ? wb_data : rf_data1.
  - op2_next is formed the same way from in_rs2 and rf_data2.
- Hazard and stall (same cycle):
  - clr[r] = wb_valid && wb_rd==r.
  - eff_busy[r] = busy[r] && !clr[r].
  - hazard = eff_busy[in_rs1] || eff_busy[in_rs2] || (in_wen && eff_busy[in_rd]).
  - in_ready = !hazard && (!out_valid || out_ready).
- Output stage (two states, EMPTY: out_valid=0 and FULL: out_valid=1):
  - On accept: register the bundle; out_valid=1 next cycle. Latency is 1 cycle from accept to out_valid.
  - out_valid && out_ready && !accept: out_valid=0 next cycle.
  - Simultaneous drain and accept: bundle replaced back-to-back, no bubble.
  - While FULL and !out_ready: outputs hold stable.
- Scoreboard update:
  - Apply clear then set: busy_next[r] = (busy[r] && !clr[r]) || (accept && in_wen && in_rd==r).
  - Simultaneous set and clear of the same register leaves it busy.
  - wb_valid to a non-busy register writes the register file and leaves busy unchanged; no error is flagged.
- All widths are fixed by the parameters. No arithmetic is performed on data.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADDR_WIDTH and DATA_WIDTH defaults.
  - NUM_REGS.
  - typedef reg_idx_t.
  - typedef data_t.
  - struct operand_bundle_t {op1, op2, rd, wen}.
- One natural sub-module: reg_scoreboard, which contains busy[], the clear/set logic and eff_busy lookups for three indices.

Test Plan:
- Reset, then wb_valid=1, wb_rd=1, wb_data=8'hFF; next cycle issue rs1=1, rs2=0, in_wen=0 -> out_op1=8'hFF, out_op2=8'h00 one cycle after accept.
- Register file holds r2=8'h11; wb_rd=2, wb_data=8'hAB in the same cycle as issue rs1=2 -> out_op1=8'hAB (forwarded, not 8'h11).
- Issue rd=3, in_wen=1, then issue rs1=3 -> in_ready=0 until wb_valid with wb_rd=3, wb_data=8'h5C; accepted that cycle with out_op1=8'h5C.
- Issue rd=4, in_wen=1, then a second instruction with rd=4, in_wen=1 -> WAW stall until wb to r4; busy[4]=1 after the second accept.
- Hold out_ready=0 with a bundle valid -> in_ready=0 and outputs stable for 5 cycles; raise out_ready while in_valid=1 -> back-to-back replacement, out_valid stays 1.
- With busy[5]=1 and out_valid=1, drive rst_n=0 for one cycle with wb_valid=1 -> rf_write_en=0, out_valid=0, busy all zero; an issue reading r5 afterwards is accepted immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU register-file front end.
package cpu_pkg;

    localparam int REG_ADDR_WIDTH = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;

    typedef struct packed {
        data_t    op1;
        data_t    op2;
        reg_idx_t rd;
        logic     wen;
    } operand_bundle_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard: one bit per register, set on issue of a writer,
// cleared by writeback. Lookups see this cycle's writeback already applied.
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  reg_idx_t q1_idx,
    input  reg_idx_t q2_idx,
    input  reg_idx_t q3_idx,
    output logic     q1_busy,
    output logic     q2_busy,
    output logic     q3_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] eff_busy;

    always_comb begin
        eff_busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            eff_busy[r] = busy_q[r] && !(clr_en && (clr_idx == reg_idx_t'(r)));
        end
    end

    // Clear is applied before set, so a same-cycle set and clear leaves the bit busy.
    always_comb begin
        busy_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = eff_busy[r] || (set_en && (set_idx == reg_idx_t'(r)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign q1_busy = eff_busy[q1_idx];
    assign q2_busy = eff_busy[q2_idx];
    assign q3_busy = eff_busy[q3_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, forwards same-cycle writeback,
// stalls on busy registers and holds one operand bundle for the execute stage.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  reg_idx_t in_rs1,
    input  reg_idx_t in_rs2,
    input  reg_idx_t in_rd,
    input  logic     in_wen,
    output logic     out_valid,
    input  logic     out_ready,
    output data_t    out_op1,
    output data_t    out_op2,
    output reg_idx_t out_rd,
    output logic     out_wen,
    input  logic     wb_valid,
    input  reg_idx_t wb_rd,
    input  data_t    wb_data,
    output reg_idx_t rf_reg1,
    output reg_idx_t rf_reg2,
    input  data_t    rf_data1,
    input  data_t    rf_data2,
    output logic     rf_write_en,
    output reg_idx_t rf_regw,
    output data_t    rf_dataw
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid is never withdrawn by this block while waiting for ready.

    out_state_e      state_q, state_d;
    operand_bundle_t bundle_q, bundle_d;
    logic            rs1_busy, rs2_busy, rd_busy;
    logic            hazard;
    logic            accept;
    data_t           op1_next, op2_next;

    assign rf_reg1     = in_rs1;
    assign rf_reg2     = in_rs2;
    assign rf_write_en = wb_valid && rst_n;
    assign rf_regw     = wb_rd;
    assign rf_dataw    = wb_data;

    // The register file returns the old value during its write cycle, so bypass it.
    assign op1_next = (wb_valid && (wb_rd == in_rs1)) ? wb_data : rf_data1;
    assign op2_next = (wb_valid && (wb_rd == in_rs2)) ? wb_data : rf_data2;

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .set_en  (accept && in_wen),
        .set_idx (in_rd),
        .q1_idx  (in_rs1),
        .q2_idx  (in_rs2),
        .q3_idx  (in_rd),
        .q1_busy (rs1_busy),
        .q2_busy (rs2_busy),
        .q3_busy (rd_busy)
    );

    assign hazard    = rs1_busy || rs2_busy || (in_wen && rd_busy);
    assign out_valid = (state_q == OUT_FULL);
    assign in_ready  = rst_n && !hazard && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        bundle_d = bundle_q;
        if (accept) begin
            state_d      = OUT_FULL;
            bundle_d.op1 = op1_next;
            bundle_d.op2 = op2_next;
            bundle_d.rd  = in_rd;
            bundle_d.wen = in_wen;
        end else if (out_valid && out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= OUT_EMPTY;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_op1 = bundle_q.op1;
    assign out_op2 = bundle_q.op2;
    assign out_rd  = bundle_q.rd;
    assign out_wen = bundle_q.wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed table-driven bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;
    import cpu_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     in_valid, in_ready;
    reg_idx_t in_rs1, in_rs2, in_rd;
    logic     in_wen;
    logic     out_valid, out_ready;
    data_t    out_op1, out_op2;
    reg_idx_t out_rd;
    logic     out_wen;
    logic     wb_valid;
    reg_idx_t wb_rd;
    data_t    wb_data;
    reg_idx_t rf_reg1, rf_reg2;
    data_t    rf_data1, rf_data2;
    logic     rf_write_en;
    reg_idx_t rf_regw;
    data_t    rf_dataw;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .rf_reg1     (rf_reg1),
        .rf_reg2     (rf_reg2),
        .rf_data1    (rf_data1),
        .rf_data2    (rf_data2),
        .rf_write_en (rf_write_en),
        .rf_regw     (rf_regw),
        .rf_dataw    (rf_dataw)
    );

    // Register file: combinational read, write at the clock edge.
    data_t rf_mem [NUM_REGS];
    assign rf_data1 = rf_mem[rf_reg1];
    assign rf_data2 = rf_mem[rf_reg2];
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_regw] <= rf_dataw;
    end

    typedef struct {
        logic     v;
        reg_idx_t rs1, rs2, rd;
        logic     wen, ordy, wbv;
        reg_idx_t wbrd;
        data_t    wbd;
        logic     e_rdy, e_ov;
        data_t    e_op1, e_op2;
        reg_idx_t e_rd;
        logic     e_wen;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(logic v, reg_idx_t rs1, reg_idx_t rs2, reg_idx_t rd, logic wen,
                                logic ordy, logic wbv, reg_idx_t wbrd, data_t wbd,
                                logic e_rdy, logic e_ov, data_t e_op1, data_t e_op2,
                                reg_idx_t e_rd, logic e_wen);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.wen = wen;
        t.ordy = ordy; t.wbv = wbv; t.wbrd = wbrd; t.wbd = wbd;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_op1 = e_op1; t.e_op2 = e_op2;
        t.e_rd = e_rd; t.e_wen = e_wen;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        in_valid  = t.v;
        in_rs1    = t.rs1;
        in_rs2    = t.rs2;
        in_rd     = t.rd;
        in_wen    = t.wen;
        out_ready = t.ordy;
        wb_valid  = t.wbv;
        wb_rd     = t.wbrd;
        wb_data   = t.wbd;
    endtask

    // Called just after a rising edge: drive, check combinational outputs, cross the
    // next edge, then check the registered bundle.
    task automatic run_vec(input int i, input vec_t t);
        string tag;
        tag = $sformatf("v%0d", i);
        drive(t);
        #2;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(t.e_rdy));
        chk({tag, "_rf_write_en"}, 32'(rf_write_en), 32'(t.wbv));
        chk({tag, "_rf_reg1"}, 32'(rf_reg1), 32'(t.rs1));
        if (t.wbv) chk({tag, "_rf_dataw"}, 32'(rf_dataw), 32'(t.wbd));
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(t.e_ov));
        if (t.e_ov) begin
            chk({tag, "_out_op1"}, 32'(out_op1), 32'(t.e_op1));
            chk({tag, "_out_op2"}, 32'(out_op2), 32'(t.e_op2));
            chk({tag, "_out_rd"}, 32'(out_rd), 32'(t.e_rd));
            chk({tag, "_out_wen"}, 32'(out_wen), 32'(t.e_wen));
        end
    endtask

    initial begin
        for (int r = 0; r < NUM_REGS; r++) rf_mem[r] = '0;
        rf_mem[2] = 8'h11;
        rf_mem[5] = 8'h55;

        //            v  rs1 rs2 rd wen ordy wbv wbrd wbd    rdy ov op1    op2    rd wen
        vecs[0]  = mk(0, 0,  0,  0, 0,  1,   1,  1,   8'hFF, 1,  0, 8'h00, 8'h00, 0, 0);
        vecs[1]  = mk(1, 1,  0,  0, 0,  1,   0,  0,   8'h00, 1,  1, 8'hFF, 8'h00, 0, 0);
        vecs[2]  = mk(1, 2,  0,  0, 0,  1,   1,  2,   8'hAB, 1,  1, 8'hAB, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0,  0,  3, 1,  1,   0,  0,   8'h00, 1,  1, 8'h00, 8'h00, 3, 1);
        vecs[4]  = mk(1, 3,  0,  0, 0,  1,   0,  0,   8'h00, 0,  0, 8'h00, 8'h00, 0, 0);
        vecs[5]  = mk(1, 3,  0,  0, 0,  1,   0,  0,   8'h00, 0,  0, 8'h00, 8'h00, 0, 0);
        vecs[6]  = mk(1, 3,  0,  0, 0,  1,   1,  3,   8'h5C, 1,  1, 8'h5C, 8'h00, 0, 0);
        vecs[7]  = mk(1, 0,  0,  4, 1,  1,   0,  0,   8'h00, 1,  1, 8'h00, 8'h00, 4, 1);
        vecs[8]  = mk(1, 1,  2,  4, 1,  1,   0,  0,   8'h00, 0,  0, 8'h00, 8'h00, 0, 0);
        vecs[9]  = mk(1, 1,  2,  4, 1,  1,   1,  4,   8'h44, 1,  1, 8'hFF, 8'hAB, 4, 1);
        vecs[10] = mk(1, 4,  0,  0, 0,  1,   0,  0,   8'h00, 0,  0, 8'h00, 8'h00, 0, 0);
        vecs[11] = mk(1, 4,  0,  0, 0,  1,   1,  4,   8'h45, 1,  1, 8'h45, 8'h00, 0, 0);
        vecs[12] = mk(1, 1,  3,  5, 1,  1,   0,  0,   8'h00, 1,  1, 8'hFF, 8'h5C, 5, 1);
        vecs[13] = mk(1, 2,  2,  6, 1,  0,   0,  0,   8'h00, 0,  1, 8'hFF, 8'h5C, 5, 1);
        vecs[14] = mk(1, 2,  2,  6, 1,  0,   0,  0,   8'h00, 0,  1, 8'hFF, 8'h5C, 5, 1);
        vecs[15] = mk(1, 2,  2,  6, 1,  0,   0,  0,   8'h00, 0,  1, 8'hFF, 8'h5C, 5, 1);
        vecs[16] = mk(1, 2,  2,  6, 1,  0,   0,  0,   8'h00, 0,  1, 8'hFF, 8'h5C, 5, 1);
        vecs[17] = mk(1, 2,  2,  6, 1,  0,   0,  0,   8'h00, 0,  1, 8'hFF, 8'h5C, 5, 1);
        vecs[18] = mk(1, 2,  2,  6, 1,  1,   0,  0,   8'h00, 1,  1, 8'hAB, 8'hAB, 6, 1);

        // Reset with a writeback pending: write port must stay quiet.
        rst_n = 1'b0;
        drive(mk(1, 0, 0, 0, 0, 1, 1, 7, 8'h77, 0, 0, 0, 0, 0, 0));
        #2;
        chk("rst_rf_write_en", 32'(rf_write_en), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_op1", 32'(out_op1), 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'h0);
        chk("rst_rf7_unwritten", 32'(rf_mem[7]), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Mid-operation reset: busy[5], busy[6] set and bundle held.
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2;
        chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
        rst_n    = 1'b0;
        wb_valid = 1'b1;
        wb_rd    = 5;
        wb_data  = 8'h99;
        #1;
        chk("mid_rst_rf_write_en", 32'(rf_write_en), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_out_rd", 32'(out_rd), 32'h0);
        rst_n = 1'b1;
        drive(mk(1, 5, 6, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
        #2;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'h1);
        chk("post_rst_out_op1", 32'(out_op1), 32'h55);
        chk("post_rst_out_op2", 32'(out_op2), 32'h00);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
